// File: rtl/serial_add_sub_framed.sv
// serial_add_sub_framed: digit-serial two's-complement adder/subtractor.
// Operands arrive DIGIT_W bits per cycle, least-significant digit first,
// framed into words of WORD_DIGITS digits. Each word is an add or a subtract
// chosen on its first digit; carry-out and signed overflow are reported
// alongside the word's most significant result digit.
module serial_add_sub_framed #(
    parameter int DIGIT_W     = 1,
    parameter int WORD_DIGITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               sub,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] sum,
    output logic               out_last,
    output logic               carry_out,
    output logic               overflow
);

    localparam int               CNT_W    = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);

    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               op;

    logic               first;
    logic               last;
    logic               op_eff;
    logic               c_in;
    logic               c_out;
    logic               c_msb;
    logic [DIGIT_W-1:0] b_eff;
    logic [DIGIT_W-1:0] s;

    // Digit datapath: first digit seeds carry-in and operation from sub,
    // later digits use the stored carry and latched operation.
    always_comb begin
        first  = (cnt == '0);
        last   = (cnt == LAST_CNT);
        op_eff = first ? sub : op;
        c_in   = first ? sub : carry;
        b_eff  = b ^ {DIGIT_W{op_eff}};
        {c_out, s} = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, c_in};
        // Carry into the digit MSB recovered from the MSB sum bit; this also
        // reduces to c_in when DIGIT_W is 1.
        c_msb  = a[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ s[DIGIT_W-1];
    end

    // Framing state and registered outputs; bubbles hold state and sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            carry     <= 1'b0;
            op        <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (in_valid) begin
            carry     <= c_out;
            if (first) begin
                op <= sub;
            end
            cnt       <= last ? '0 : cnt + CNT_W'(1);
            out_valid <= 1'b1;
            sum       <= s;
            out_last  <= last;
            carry_out <= last & c_out;
            overflow  <= last & (c_out ^ c_msb);
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_add_sub_framed.sv
// Self-checking bench for serial_add_sub_framed: a 4x4-digit instance and a
// 1x16-bit instance, compared word-by-word against an integer reference.
`timescale 1ns/1ps
module tb_serial_add_sub_framed;

    typedef struct {
        longint val;
        bit     co;
        bit     ov;
        int     nd;
    } word_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit digit, 4-digit word instance
    logic       rst4 = 1'b1, iv4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ov4, last4, co4, of4;
    logic [3:0] sum4;

    // 1-bit digit, 16-digit word instance
    logic       rst1 = 1'b1, iv1 = 1'b0, sub1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       ov1, last1, co1, of1;
    logic [0:0] sum1;

    serial_add_sub_framed #(.DIGIT_W(4), .WORD_DIGITS(4)) u4 (
        .clk(clk), .rst(rst4), .in_valid(iv4), .a(a4), .b(b4), .sub(sub4),
        .out_valid(ov4), .sum(sum4), .out_last(last4),
        .carry_out(co4), .overflow(of4)
    );

    serial_add_sub_framed #(.DIGIT_W(1), .WORD_DIGITS(16)) u1 (
        .clk(clk), .rst(rst1), .in_valid(iv1), .a(a1), .b(b1), .sub(sub1),
        .out_valid(ov1), .sum(sum1), .out_last(last1),
        .carry_out(co1), .overflow(of1)
    );

    int checks = 0;
    int errors = 0;

    word_t  wq4[$], wq1[$];
    longint acc4 = 0, acc1 = 0;
    int     nd4 = 0, nd1 = 0, vcount4 = 0, stray4 = 0, stray1 = 0;

    // Reassemble result words from the output digit streams.
    always @(negedge clk) begin
        if (rst4) begin
            acc4 = 0; nd4 = 0;
        end else if (ov4) begin
            acc4 = acc4 | (longint'(sum4) << (4 * nd4));
            nd4++; vcount4++;
            if (last4) begin
                wq4.push_back('{acc4, co4, of4, nd4});
                acc4 = 0; nd4 = 0;
            end else if (co4 || of4) stray4++;
        end else if (last4 || co4 || of4) stray4++;
    end

    always @(negedge clk) begin
        if (rst1) begin
            acc1 = 0; nd1 = 0;
        end else if (ov1) begin
            acc1 = acc1 | (longint'(sum1) << nd1);
            nd1++;
            if (last1) begin
                wq1.push_back('{acc1, co1, of1, nd1});
                acc1 = 0; nd1 = 0;
            end else if (co1 || of1) stray1++;
        end else if (last1 || co1 || of1) stray1++;
    end

    // Reference: plain integer arithmetic on whole n-bit words.
    function automatic word_t ref_word(input int n, input longint a, input longint b, input bit s);
        word_t  w;
        longint m    = (longint'(1) << n) - 1;
        longint half = longint'(1) << (n - 1);
        longint sa   = (a >= half) ? a - 2 * half : a;
        longint sb   = (b >= half) ? b - 2 * half : b;
        longint r    = s ? sa - sb : sa + sb;
        w.val = s ? ((a - b) & m) : ((a + b) & m);
        w.co  = s ? (a >= b) : (((a + b) >> n) != 0);
        w.ov  = (r < -half) || (r >= half);
        w.nd  = (n == 16 && m == 16'hFFFF) ? 0 : 0;
        return w;
    endfunction

    task automatic drive4(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input int min_bub, input int max_bub, input bit noise);
        for (int d = 0; d < 4; d++) begin
            if (d > 0 && max_bub > 0) begin
                int nb = $urandom_range(max_bub, min_bub);
                for (int k = 0; k < nb; k++) begin
                    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
            iv4  = 1'b1;
            a4   = a[4*d +: 4];
            b4   = b[4*d +: 4];
            sub4 = (d == 0 || !noise) ? s : 1'($urandom);
            @(posedge clk); #1;
        end
        iv4 = 1'b0;
    endtask

    task automatic drive1(input logic [15:0] a, input logic [15:0] b, input logic s);
        for (int d = 0; d < 16; d++) begin
            iv1  = 1'b1;
            a1   = a[d +: 1];
            b1   = b[d +: 1];
            sub1 = (d == 0) ? s : 1'($urandom);
            @(posedge clk); #1;
        end
        iv1 = 1'b0;
    endtask

    task automatic wait_words4(input int n);
        int t = 0;
        while (wq4.size() < n && t < 40) begin @(posedge clk); #1; t++; end
        checks++;
        if (wq4.size() < n) begin
            errors++;
            $display("FAIL wait_words4: got %0d words, required %0d", wq4.size(), n);
        end
    endtask

    task automatic wait_words1(input int n);
        int t = 0;
        while (wq1.size() < n && t < 60) begin @(posedge clk); #1; t++; end
        checks++;
        if (wq1.size() < n) begin
            errors++;
            $display("FAIL wait_words1: got %0d words, required %0d", wq1.size(), n);
        end
    endtask

    task automatic test_reset;
        rst4 = 1'b1; rst1 = 1'b1; iv4 = 1'b1; iv1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if ({ov4, sum4, last4, co4, of4} !== 8'h00) begin
            errors++; $display("FAIL reset4: outputs %b required 0", {ov4, sum4, last4, co4, of4});
        end
        if ({ov1, sum1, last1, co1, of1} !== 5'h00) begin
            errors++; $display("FAIL reset1: outputs %b required 0", {ov1, sum1, last1, co1, of1});
        end
        rst4 = 1'b0; rst1 = 1'b0; iv4 = 1'b0; iv1 = 1'b0;
        wq4.delete(); wq1.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_vectors;
        logic [15:0] va[5] = '{16'h1234, 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF};
        logic [15:0] vb[5] = '{16'h0FFF, 16'h1235, 16'h0001, 16'h0001, 16'h0001};
        logic        vs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) drive4(va[i], vb[i], vs[i], 0, 0, 1'b1);
        wait_words4(5);
        for (int i = 0; i < 5 && wq4.size() > 0; i++) begin
            word_t got = wq4.pop_front();
            word_t exp = ref_word(16, longint'(va[i]), longint'(vb[i]), vs[i]);
            checks++;
            if (got.val !== exp.val || got.co !== exp.co || got.ov !== exp.ov || got.nd != 4) begin
                errors++;
                $display("FAIL vector%0d: sum=%h co=%b ov=%b nd=%0d required sum=%h co=%b ov=%b nd=4",
                         i, got.val, got.co, got.ov, got.nd, exp.val, exp.co, exp.ov);
            end
        end
    endtask

    task automatic test_bubbles;
        word_t exp = ref_word(16, 64'h1234, 64'h0FFF, 1'b0);
        vcount4 = 0;
        drive4(16'h1234, 16'h0FFF, 1'b0, 1, 3, 1'b1);
        wait_words4(1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vcount4 != 4) begin
            errors++; $display("FAIL bubble_valid_count: got %0d required 4", vcount4);
        end
        if (wq4.size() > 0) begin
            word_t got = wq4.pop_front();
            checks++;
            if (got.val !== exp.val || got.co !== exp.co || got.ov !== exp.ov) begin
                errors++;
                $display("FAIL bubble_word: sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                         got.val, got.co, got.ov, exp.val, exp.co, exp.ov);
            end
        end
    endtask

    task automatic test_reset_midword;
        wq4.delete();
        for (int d = 0; d < 2; d++) begin
            iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF; sub4 = 1'b0;
            @(posedge clk); #1;
        end
        rst4 = 1'b1; iv4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom);
        @(posedge clk); #1;
        rst4 = 1'b0; iv4 = 1'b0;
        checks++;
        if ({ov4, sum4, last4, co4, of4} !== 8'h00) begin
            errors++; $display("FAIL post_reset_outputs: %b required 0", {ov4, sum4, last4, co4, of4});
        end
        drive4(16'h0001, 16'h0001, 1'b0, 0, 0, 1'b0);
        wait_words4(1);
        if (wq4.size() > 0) begin
            word_t got = wq4.pop_front();
            checks++;
            if (got.val !== 64'h0002 || got.co !== 1'b0 || got.ov !== 1'b0 || got.nd != 4) begin
                errors++;
                $display("FAIL reset_midword_word: sum=%h co=%b ov=%b nd=%0d required sum=0002 co=0 ov=0 nd=4",
                         got.val, got.co, got.ov, got.nd);
            end
        end
    endtask

    task automatic test_random4;
        word_t       expq[$];
        logic [15:0] ra, rb;
        logic        rs;
        wq4.delete();
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            expq.push_back(ref_word(16, longint'(ra), longint'(rb), rs));
            drive4(ra, rb, rs, 0, 2, 1'b1);
        end
        wait_words4(40);
        while (wq4.size() > 0 && expq.size() > 0) begin
            word_t got = wq4.pop_front();
            word_t exp = expq.pop_front();
            checks++;
            if (got.val !== exp.val || got.co !== exp.co || got.ov !== exp.ov || got.nd != 4) begin
                errors++;
                $display("FAIL random4: sum=%h co=%b ov=%b nd=%0d required sum=%h co=%b ov=%b nd=4",
                         got.val, got.co, got.ov, got.nd, exp.val, exp.co, exp.ov);
            end
        end
    endtask

    task automatic test_serial1;
        word_t       expq[$];
        logic [15:0] ra, rb;
        logic        rs;
        wq1.delete();
        expq.push_back(ref_word(16, 64'h8192, 64'h2154, 1'b0));
        drive1(16'h8192, 16'h2154, 1'b0);
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            expq.push_back(ref_word(16, longint'(ra), longint'(rb), rs));
            drive1(ra, rb, rs);
        end
        wait_words1(13);
        while (wq1.size() > 0 && expq.size() > 0) begin
            word_t got = wq1.pop_front();
            word_t exp = expq.pop_front();
            checks++;
            if (got.val !== exp.val || got.co !== exp.co || got.ov !== exp.ov || got.nd != 16) begin
                errors++;
                $display("FAIL serial1: sum=%h co=%b ov=%b nd=%0d required sum=%h co=%b ov=%b nd=16",
                         got.val, got.co, got.ov, got.nd, exp.val, exp.co, exp.ov);
            end
        end
    endtask

    task automatic test_flags_outside_last;
        checks += 2;
        if (stray4 != 0) begin
            errors++; $display("FAIL flags_outside_last4: got %0d cycles required 0", stray4);
        end
        if (stray1 != 0) begin
            errors++; $display("FAIL flags_outside_last1: got %0d cycles required 0", stray1);
        end
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_bubbles;
        test_reset_midword;
        test_random4;
        test_serial1;
        repeat (3) @(posedge clk);
        test_flags_outside_last;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
